// File: rtl/mac_frame_controller.sv
// Frame-buffered signed multiply-add engine: loads 1..DEPTH operand words, then
// streams requantised per-element or dot-product results over valid/ready.
module mac_frame_controller #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ACC_W      = 24,
  parameter int FRAC_SHIFT = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [$clog2(DEPTH):0] len,
  input  logic [4*DATA_W-1:0]    in_data,
  input  logic                   r_valid,
  output logic                   r_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   t_valid,
  input  logic                   t_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LEN_W = AW + 1;
  localparam int OPS_W = 3 * DATA_W;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, RD, EXE, SEND} state_t;

  state_t                    state_q, state_d;
  logic                      mode_q, mode_d;
  logic [LEN_W-1:0]          n_q, n_d;
  logic [LEN_W-1:0]          wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]          rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0]          len_eff, n_last;
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum, prod_ext, c_ext, q;
  logic [DATA_W-1:0]         out_q, out_d, sat;
  logic                      done_q, done_d;
  logic                      accept, wr_en;
  logic [AW-1:0]             wr_addr;
  logic [OPS_W-1:0]          mem [DEPTH];
  logic [OPS_W-1:0]          rd_data_q;
  logic signed [2*DATA_W-1:0] op_a, op_b, prod;
  logic                      unused_top;

  assign unused_top = ^in_data[4*DATA_W-1:OPS_W];

  assign r_ready  = !rst && (state_q == IDLE || state_q == LOAD);
  assign accept   = r_valid && r_ready;
  assign t_valid  = (state_q == SEND);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign out_data = out_q;

  assign len_eff = (len == '0 || len > MAX_LEN) ? MAX_LEN : len;
  assign n_last  = n_q - ONE;

  // Operands are widened before the multiply so the product is a full signed 2*DATA_W result.
  assign op_a     = {{DATA_W{rd_data_q[DATA_W-1]}}, rd_data_q[DATA_W-1:0]};
  assign op_b     = {{DATA_W{rd_data_q[2*DATA_W-1]}}, rd_data_q[2*DATA_W-1:DATA_W]};
  assign prod     = op_a * op_b;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign c_ext    = {{(ACC_W-DATA_W){rd_data_q[OPS_W-1]}}, rd_data_q[OPS_W-1:2*DATA_W]};
  assign acc_sum  = mode_q ? (((rd_cnt_q == '0) ? c_ext : acc_q) + prod_ext)
                           : (prod_ext + c_ext);

  assign q   = acc_sum >>> FRAC_SHIFT;
  assign sat = (&q[ACC_W-1:DATA_W-1] || !(|q[ACC_W-1:DATA_W-1]))
             ? q[DATA_W-1:0]
             : {q[ACC_W-1], {(DATA_W-1){~q[ACC_W-1]}}};

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path infers a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    n_d      = n_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    acc_d    = acc_q;
    out_d    = out_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = wr_cnt_q[AW-1:0];
    case (state_q)
      IDLE: if (accept) begin
        mode_d   = mode;
        n_d      = len_eff;
        wr_en    = 1'b1;
        wr_addr  = '0;
        wr_cnt_d = ONE;
        rd_cnt_d = '0;
        state_d  = (len_eff == ONE) ? RD : LOAD;
      end
      LOAD: if (accept) begin
        wr_en    = 1'b1;
        wr_cnt_d = wr_cnt_q + ONE;
        if (wr_cnt_d == n_q) begin
          rd_cnt_d = '0;
          state_d  = RD;
        end
      end
      RD: state_d = EXE;
      EXE: begin
        acc_d = acc_sum;
        if (!mode_q || rd_cnt_q == n_last) begin
          out_d   = sat;
          state_d = SEND;
        end else begin
          rd_cnt_d = rd_cnt_q + ONE;
          state_d  = RD;
        end
      end
      SEND: if (t_ready) begin
        if (!mode_q && rd_cnt_q != n_last) begin
          rd_cnt_d = rd_cnt_q + ONE;
          state_d  = RD;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      n_q      <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      n_q      <= n_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      acc_q    <= acc_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the buffer has no reset; each entry of a frame is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in_data[OPS_W-1:0];
    rd_data_q <= mem[rd_cnt_q[AW-1:0]];
  end

endmodule

// File: tb/tb_mac_frame_controller.sv
// Directed and randomised frames checked against an arithmetic reference model
// (floor-shift, clamp, per-element or dot-product sums) with latency and handshake checks.
module tb_mac_frame_controller;
  localparam int DEPTH = 16;
  localparam int FRAC  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [4:0] len = '0;
  logic [31:0] in_data = '0;
  logic       r_valid = 1'b0;
  logic       t_ready = 1'b1;
  logic       r_ready, t_valid, busy, done;
  logic [7:0] out_data;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int fa [DEPTH+1];
  int fb [DEPTH+1];
  int fc [DEPTH+1];
  logic [7:0] exp_q [$];

  mac_frame_controller dut (
    .clk(clk), .rst(rst), .mode(mode), .len(len), .in_data(in_data),
    .r_valid(r_valid), .r_ready(r_ready), .out_data(out_data), .t_valid(t_valid),
    .t_ready(t_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division by 2^FRAC, then clamp to the signed 8-bit range.
  function automatic logic [7:0] requant(input int v);
    int d, r;
    d = 1 << FRAC;
    r = v / d;
    if ((v % d) != 0 && v < 0) r = r - 1;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  task automatic build_model(input logic m, input int n);
    int s;
    exp_q.delete();
    if (!m) begin
      for (int i = 0; i < n; i++) exp_q.push_back(requant(fa[i] * fb[i] + fc[i]));
    end else begin
      s = fc[0];
      for (int i = 0; i < n; i++) s += fa[i] * fb[i];
      exp_q.push_back(requant(s));
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c);
    fa[i] = a; fb[i] = b; fc[i] = c;
  endtask

  task automatic rand_ops();
    for (int i = 0; i <= DEPTH; i++) begin
      if ($urandom_range(0, 4) == 0) set_op(i, ($urandom_range(0, 1) != 0) ? 127 : -128, -128, 127);
      else set_op(i, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  int'($urandom_range(0, 255)) - 128);
    end
  endtask

  // Called at a negedge with the DUT idle. bp_idx selects the output held back for bp_len cycles.
  task automatic run_frame(input logic m, input int len_f, input int nbeats,
                           input int bp_idx, input int bp_len);
    int n_eff, ref_cyc, lat, last;
    logic [7:0] held;
    n_eff = (len_f == 0 || len_f > DEPTH) ? DEPTH : len_f;
    build_model(m, n_eff);
    last = exp_q.size() - 1;
    ref_cyc = cyc;
    for (int i = 0; i < nbeats; i++) begin
      if (i == 0) begin
        mode = m;
        len  = 5'(len_f);
      end else begin
        mode = 1'($urandom);
        len  = 5'($urandom);
      end
      r_valid = 1'b1;
      in_data = {8'($urandom), 8'(fc[i]), 8'(fb[i]), 8'(fa[i])};
      check("r_ready_beat", r_ready, (i < n_eff));
      if (i == n_eff - 1) ref_cyc = cyc;
      @(negedge clk);
    end
    r_valid = 1'b0;
    for (int k = 0; k <= last; k++) begin
      t_ready = (k != bp_idx);
      while (t_valid !== 1'b1 && (cyc - ref_cyc) < 100) @(negedge clk);
      check("t_valid_rise", t_valid, 1'b1);
      lat = cyc - ref_cyc;
      check("latency", lat, (k == 0 && m) ? 2 * n_eff + 1 : 3);
      held = out_data;
      if (k == bp_idx) begin
        for (int w = 0; w < bp_len; w++) begin
          @(negedge clk);
          check("bp_t_valid", t_valid, 1'b1);
          check("bp_stable", out_data, held);
        end
      end
      check("out_data", out_data, exp_q[k]);
      t_ready = 1'b1;
      ref_cyc = cyc;
      @(negedge clk);
      check("t_valid_drop", t_valid, 1'b0);
      check("done", done, (k == last));
      if (k == last) begin
        check("busy_after", busy, 1'b0);
        check("r_ready_done", r_ready, 1'b1);
        @(negedge clk);
        check("done_pulse_end", done, 1'b0);
        check("no_extra_out", t_valid, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_r_ready", r_ready, 1'b0);
    check("rst_t_valid", t_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_r_ready", r_ready, 1'b1);

    // Per-element, single element
    set_op(0, 64, 64, 0);
    run_frame(1'b0, 1, 1, -1, 0);
    check("model_64", exp_q[0], 8'h40);

    // Saturation both directions
    set_op(0, 127, 127, 127);
    set_op(1, -128, 127, 0);
    run_frame(1'b0, 2, 2, -1, 0);

    // Dot product; c of elements 1..3 must be ignored
    for (int i = 0; i < 4; i++) set_op(i, 16, 16, (i == 0) ? 64 : 99);
    run_frame(1'b1, 4, 4, -1, 0);

    // Backpressure on the middle output
    rand_ops();
    run_frame(1'b0, 3, 3, 1, 5);

    // Full depth with one surplus beat, then dot product with len > DEPTH
    rand_ops();
    run_frame(1'b0, 0, DEPTH + 1, -1, 0);
    rand_ops();
    run_frame(1'b1, 31, DEPTH, 0, 2);

    // Reset in the middle of a load
    rand_ops();
    mode = 1'b0;
    len  = 5'd5;
    r_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = {8'hA5, 8'(fc[i]), 8'(fb[i]), 8'(fa[i])};
      @(negedge clk);
    end
    r_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_r_ready", r_ready, 1'b0);
    @(negedge clk);
    check("midrst_t_valid", t_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    set_op(0, 2, 3, 4);
    run_frame(1'b0, 1, 1, -1, 0);

    // Randomised frames
    for (int r = 0; r < 10; r++) begin
      logic m;
      int lf, ne, bi;
      m  = 1'($urandom);
      lf = $urandom_range(0, 31);
      ne = (lf == 0 || lf > DEPTH) ? DEPTH : lf;
      bi = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, m ? 0 : ne - 1)) : -1;
      rand_ops();
      run_frame(m, lf, ne, bi, $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
